bp_tile_sched: RTL and testbench

Layer-level tile scheduler for the bit-parallel DSP array. Latches one layer's dimensions, splits them into HW×K subtiles with edge-tile remainder handling, and sequences each subtile through load → execute → store. It drives the subtile sizes and `bp_ex_tile_start` into the execute-address controller and handshakes with the buffer load and store engines.

---
 rtl/bp_sched_pkg.sv | 23 ++
 rtl/bp_tile_min.sv | 32 +++
 rtl/bp_tile_sched.sv | 174 +++++++++++++++++
 tb/tb_bp_tile_sched.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_sched_pkg.sv
// bp_sched_pkg
// Shared definitions for the bit-parallel tile scheduler:
//   - bp_sched_state_t : scheduler state encoding
//   - DIM_W            : width of layer dimensions and tile offsets (16)
//   - SUB_W            : width of a subtile size (8)
//   - HWCIJ_W          : width of the subtile HW*CIJ product (24)
package bp_sched_pkg;

  localparam int DIM_W   = 16;
  localparam int SUB_W   = 8;
  localparam int HWCIJ_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    LOAD,
    EXEC,
    STORE,
    NEXT,
    DONE
  } bp_sched_state_t;

endpackage

// File: rtl/bp_tile_min.sv
// bp_tile_min
// Combinational subtile sizing: min(total - base, MAX_SUBTILE), narrowed to
// the subtile width. The caller guarantees base <= total whenever the result
// is used, so the subtraction never underflows in practice.
// Parameters:
//   MAX_SUBTILE : largest subtile along this dimension (1..255)
// Ports:
//   total   in  DIM_W : full layer dimension
//   base    in  DIM_W : base offset of the current subtile
//   subtile out SUB_W : size of the current subtile
module bp_tile_min
  import bp_sched_pkg::*;
#(
  parameter int MAX_SUBTILE = 64
) (
  input  logic [DIM_W-1:0] total,
  input  logic [DIM_W-1:0] base,
  output logic [SUB_W-1:0] subtile
);

  localparam logic [DIM_W-1:0] MAX_W = DIM_W'(MAX_SUBTILE);

  logic [DIM_W-1:0] remaining;
  logic [DIM_W-1:0] clipped;

  always_comb begin
    remaining = total - base;
    clipped   = (remaining < MAX_W) ? remaining : MAX_W;
    subtile   = SUB_W'(clipped);
  end

endmodule

// File: rtl/bp_tile_sched.sv
// bp_tile_sched
// Layer-level tile scheduler for the bit-parallel DSP array. Latches one
// layer's HW/K/CIJ, walks it in HW x K subtiles (K inner loop, edge tiles
// clipped to the remainder) and runs each subtile through load, execute
// and store handshakes.
// Optional feature macro: BP_TILE_SCHED_PERF_EN adds three saturating
// 32-bit performance counters (busy, execute, load+store stall cycles).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_start                start pulse, ignored while busy
//   cfg_HW/cfg_K/cfg_CIJ     layer dimensions
//   bp_subtile_HW/K/CIJ      current subtile sizes and reduction depth
//   bp_opt_subtile_HWCIJ     registered subtile HW*CIJ
//   ld_req/ld_done           load engine handshake
//   bp_ex_tile_start/_end    execute controller handshake
//   st_req/st_done           store engine handshake
//   tile_hw_idx/tile_k_idx   base offsets of the current subtile
//   sched_busy, sched_done   status
//   perf_*                   counters (only with BP_TILE_SCHED_PERF_EN)
module bp_tile_sched
  import bp_sched_pkg::*;
#(
  parameter int MAX_SUBTILE_HW = 64,
  parameter int MAX_SUBTILE_K  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [DIM_W-1:0]    cfg_HW,
  input  logic [DIM_W-1:0]    cfg_K,
  input  logic [DIM_W-1:0]    cfg_CIJ,
  output logic [SUB_W-1:0]    bp_subtile_HW,
  output logic [SUB_W-1:0]    bp_subtile_K,
  output logic [DIM_W-1:0]    bp_subtile_CIJ,
  output logic [HWCIJ_W-1:0]  bp_opt_subtile_HWCIJ,
  output logic                ld_req,
  input  logic                ld_done,
  output logic                bp_ex_tile_start,
  input  logic                bp_ex_tile_end,
  output logic                st_req,
  input  logic                st_done,
  output logic [DIM_W-1:0]    tile_hw_idx,
  output logic [DIM_W-1:0]    tile_k_idx,
  output logic                sched_busy,
  output logic                sched_done
`ifdef BP_TILE_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_busy_cycles,
  output logic [31:0]         perf_ex_cycles,
  output logic [31:0]         perf_stall_cycles
`endif
);

  bp_sched_state_t state, state_nxt;

  logic [DIM_W-1:0] hw_q, k_q, cij_q;
  logic [SUB_W-1:0] sub_hw_c, sub_k_c;
  logic [DIM_W:0]   k_sum, hw_sum;
  logic             k_wrap, hw_end, dims_zero;

  bp_tile_min #(.MAX_SUBTILE(MAX_SUBTILE_HW)) u_min_hw (
    .total   (hw_q),
    .base    (tile_hw_idx),
    .subtile (sub_hw_c)
  );

  bp_tile_min #(.MAX_SUBTILE(MAX_SUBTILE_K)) u_min_k (
    .total   (k_q),
    .base    (tile_k_idx),
    .subtile (sub_k_c)
  );

  // Offset advance uses one extra bit so offsets close to 65535 cannot wrap
  // back below the layer size and restart the walk.
  always_comb begin
    k_sum     = {1'b0, tile_k_idx} + (DIM_W+1)'(MAX_SUBTILE_K);
    hw_sum    = {1'b0, tile_hw_idx} + (DIM_W+1)'(MAX_SUBTILE_HW);
    k_wrap    = (k_sum >= {1'b0, k_q});
    hw_end    = (hw_sum >= {1'b0, hw_q});
    dims_zero = (hw_q == '0) || (k_q == '0) || (cij_q == '0);
  end

  // A tile-end arriving together with the start pulse is too early for the
  // execute controller, so it is only honoured after the first EXEC cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = CALC;
      CALC:    state_nxt = dims_zero ? DONE : LOAD;
      LOAD:    if (ld_done) state_nxt = EXEC;
      EXEC:    if (bp_ex_tile_end && !bp_ex_tile_start) state_nxt = STORE;
      STORE:   if (st_done) state_nxt = NEXT;
      NEXT:    state_nxt = (k_wrap && hw_end) ? DONE : CALC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs are decoded from the next state so they
  // come straight out of flops and line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      hw_q                 <= '0;
      k_q                  <= '0;
      cij_q                <= '0;
      tile_hw_idx          <= '0;
      tile_k_idx           <= '0;
      bp_subtile_HW        <= '0;
      bp_subtile_K         <= '0;
      bp_subtile_CIJ       <= '0;
      bp_opt_subtile_HWCIJ <= '0;
      ld_req               <= 1'b0;
      st_req               <= 1'b0;
      bp_ex_tile_start     <= 1'b0;
      sched_busy           <= 1'b0;
      sched_done           <= 1'b0;
    end else begin
      state            <= state_nxt;
      ld_req           <= (state_nxt == LOAD);
      st_req           <= (state_nxt == STORE);
      bp_ex_tile_start <= (state_nxt == EXEC) && (state != EXEC);
      sched_busy       <= (state_nxt != IDLE);
      sched_done       <= (state_nxt == DONE);

      if (state == IDLE && cfg_start) begin
        hw_q        <= cfg_HW;
        k_q         <= cfg_K;
        cij_q       <= cfg_CIJ;
        tile_hw_idx <= '0;
        tile_k_idx  <= '0;
      end

      if (state == CALC) begin
        bp_subtile_HW        <= sub_hw_c;
        bp_subtile_K         <= sub_k_c;
        bp_subtile_CIJ       <= cij_q;
        bp_opt_subtile_HWCIJ <= HWCIJ_W'(sub_hw_c) * HWCIJ_W'(cij_q);
      end

      if (state == NEXT) begin
        if (k_wrap) begin
          tile_k_idx  <= '0;
          tile_hw_idx <= DIM_W'(hw_sum);
        end else begin
          tile_k_idx  <= DIM_W'(k_sum);
        end
      end
    end
  end

`ifdef BP_TILE_SCHED_PERF_EN
  // Saturating counters, restarted by every accepted layer start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cycles  <= '0;
      perf_ex_cycles    <= '0;
      perf_stall_cycles <= '0;
    end else if (state == IDLE && cfg_start) begin
      perf_busy_cycles  <= '0;
      perf_ex_cycles    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (state != IDLE && perf_busy_cycles != '1)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (state == EXEC && perf_ex_cycles != '1)
        perf_ex_cycles <= perf_ex_cycles + 32'd1;
      if ((state == LOAD || state == STORE) && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_tile_sched.sv
// tb_bp_tile_sched
// Self-checking bench for bp_tile_sched (MAX_SUBTILE_HW/K = 64). A
// transaction-level model builds the expected subtile list for each layer
// with nested loops and tracks which handshake the scheduler is waiting on;
// a compare process checks the DUT against it every cycle. Directed layers
// pin the model with hand-computed tile lists, latencies and counts.
// Perf counters are checked when BP_TILE_SCHED_PERF_EN is defined.
module tb_bp_tile_sched;

  localparam int MAX_HW = 64;
  localparam int MAX_K  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_HW = '0, cfg_K = '0, cfg_CIJ = '0;
  logic [7:0]  bp_subtile_HW, bp_subtile_K;
  logic [15:0] bp_subtile_CIJ;
  logic [23:0] bp_opt_subtile_HWCIJ;
  logic        ld_req, st_req, bp_ex_tile_start, sched_busy, sched_done;
  logic        ld_done = 1'b0, bp_ex_tile_end = 1'b0, st_done = 1'b0;
  logic [15:0] tile_hw_idx, tile_k_idx;
`ifdef BP_TILE_SCHED_PERF_EN
  logic [31:0] perf_busy_cycles, perf_ex_cycles, perf_stall_cycles;
`endif

  bp_tile_sched #(.MAX_SUBTILE_HW(MAX_HW), .MAX_SUBTILE_K(MAX_K)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cfg_start            (cfg_start),
    .cfg_HW               (cfg_HW),
    .cfg_K                (cfg_K),
    .cfg_CIJ              (cfg_CIJ),
    .bp_subtile_HW        (bp_subtile_HW),
    .bp_subtile_K         (bp_subtile_K),
    .bp_subtile_CIJ       (bp_subtile_CIJ),
    .bp_opt_subtile_HWCIJ (bp_opt_subtile_HWCIJ),
    .ld_req               (ld_req),
    .ld_done              (ld_done),
    .bp_ex_tile_start     (bp_ex_tile_start),
    .bp_ex_tile_end       (bp_ex_tile_end),
    .st_req               (st_req),
    .st_done              (st_done),
    .tile_hw_idx          (tile_hw_idx),
    .tile_k_idx           (tile_k_idx),
    .sched_busy           (sched_busy),
    .sched_done           (sched_done)
`ifdef BP_TILE_SCHED_PERF_EN
    ,
    .perf_busy_cycles     (perf_busy_cycles),
    .perf_ex_cycles       (perf_ex_cycles),
    .perf_stall_cycles    (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  typedef struct {
    int hw_idx;
    int k_idx;
    int sub_hw;
    int sub_k;
    int hwcij;
  } tile_t;

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_GAP, M_LOAD, M_EXEC, M_STORE, M_DONE} m_mode_t;
  m_mode_t m_mode = M_IDLE;
  int      m_gap = 0;
  bit      m_first = 0;
  int      m_cij = 0;
  tile_t   m_cur = '{0, 0, 0, 0, 0};
  tile_t   mq[$];

  task automatic build_tiles(input int hw, input int k, input int cij);
    tile_t t;
    mq.delete();
    if (hw == 0 || k == 0 || cij == 0) return;
    for (int h = 0; h < hw; h += MAX_HW)
      for (int kk = 0; kk < k; kk += MAX_K) begin
        t.hw_idx = h;
        t.k_idx  = kk;
        t.sub_hw = (hw - h < MAX_HW) ? hw - h : MAX_HW;
        t.sub_k  = (k - kk < MAX_K) ? k - kk : MAX_K;
        t.hwcij  = t.sub_hw * cij;
        mq.push_back(t);
      end
  endtask

  // Gap lengths: one setup cycle before the first load (or before done on an
  // empty layer), two between tiles, one between the last store and done.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  = M_IDLE;
      m_first = 0;
      mq.delete();
    end else begin
      case (m_mode)
        M_IDLE: if (cfg_start) begin
          build_tiles(int'(cfg_HW), int'(cfg_K), int'(cfg_CIJ));
          m_cij  = int'(cfg_CIJ);
          m_mode = M_GAP;
          m_gap  = 1;
        end
        M_GAP: begin
          m_gap--;
          if (m_gap == 0) begin
            if (mq.size() == 0) m_mode = M_DONE;
            else begin
              m_cur  = mq.pop_front();
              m_mode = M_LOAD;
            end
          end
        end
        M_LOAD: if (ld_done) begin
          m_mode  = M_EXEC;
          m_first = 1;
        end
        M_EXEC: begin
          if (!m_first && bp_ex_tile_end) m_mode = M_STORE;
          m_first = 0;
        end
        M_STORE: if (st_done) begin
          m_mode = M_GAP;
          m_gap  = (mq.size() != 0) ? 2 : 1;
        end
        M_DONE: m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      checkOutput("ctrl", {59'd0, sched_busy, ld_req, st_req, bp_ex_tile_start, sched_done},
                  {59'd0, m_mode != M_IDLE, m_mode == M_LOAD, m_mode == M_STORE,
                   m_mode == M_EXEC && m_first, m_mode == M_DONE});
      if (m_mode == M_LOAD || m_mode == M_EXEC || m_mode == M_STORE) begin
        checkOutput("subtile", {32'd0, bp_subtile_HW, bp_subtile_K, bp_subtile_CIJ},
                    {32'd0, 8'(m_cur.sub_hw), 8'(m_cur.sub_k), 16'(m_cij)});
        checkOutput("hwcij_idx", {8'd0, bp_opt_subtile_HWCIJ, tile_hw_idx, tile_k_idx},
                    {8'd0, 24'(m_cur.hwcij), 16'(m_cur.hw_idx), 16'(m_cur.k_idx)});
      end
    end
  end

  // Event log used by the literal checks.
  tile_t logq[$];
  int    done_cnt = 0;
  int    ld_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bp_ex_tile_start)
        logq.push_back('{int'(tile_hw_idx), int'(tile_k_idx), int'(bp_subtile_HW),
                         int'(bp_subtile_K), int'(bp_opt_subtile_HWCIJ)});
      if (sched_done) done_cnt++;
      if (ld_req) ld_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ld_or_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (ld_req || sched_done) begin
        ok = 1;
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("[TB] FAIL wait_timeout actual=no_ld_req_or_done required=event_within_200_cycles");
  endtask

  task automatic applyStimulus(input int hw, input int k, input int cij,
                               input int ld_d, input int ex_d, input int st_d, input bit noise);
    int  c0, st_cyc;
    bit  ok, first;
    logq.delete();
    done_cnt = 0;
    ld_cnt   = 0;
    first    = 1;
    st_cyc   = 0;
    @(negedge clk);
    cfg_HW = 16'(hw); cfg_K = 16'(k); cfg_CIJ = 16'(cij);
    cfg_start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int guard = 0; guard < 64; guard++) begin
      wait_ld_or_done(ok);
      if (!ok || sched_done) break;
      if (first) checkOutput("cfg_to_ld", 64'(cyc - c0), 64'd2);
      else       checkOutput("st_to_ld", 64'(cyc - st_cyc), 64'd3);
      first = 0;
      repeat (ld_d - 1) @(negedge clk);
      ld_done = 1'b1;
      @(negedge clk);
      ld_done = 1'b0;
      checkOutput("ld_to_start", {63'd0, bp_ex_tile_start}, 64'd1);
      if (noise) begin
        ld_done = 1'b1; cfg_start = 1'b1; bp_ex_tile_end = 1'b1; cfg_HW = 16'd5;
        @(negedge clk);
        ld_done = 1'b0; cfg_start = 1'b0; bp_ex_tile_end = 1'b0; cfg_HW = 16'(hw);
        repeat (ex_d - 2) @(negedge clk);
      end else begin
        repeat (ex_d - 1) @(negedge clk);
      end
      bp_ex_tile_end = 1'b1;
      @(negedge clk);
      bp_ex_tile_end = 1'b0;
      repeat (st_d - 1) @(negedge clk);
      st_done = 1'b1;
      st_cyc = cyc;
      @(negedge clk);
      st_done = 1'b0;
      checkOutput("st_req_drop", {63'd0, st_req}, 64'd0);
    end
    if (sched_done) begin
      if (first) checkOutput("cfg_to_done", 64'(cyc - c0), 64'd2);
      else       checkOutput("st_to_done", 64'(cyc - st_cyc), 64'd2);
      @(negedge clk);
      checkOutput("busy_fall", {62'd0, sched_busy, sched_done}, 64'd0);
    end
  endtask

  task automatic check_square_log(input string tag);
    int exp_hw[4] = '{0, 0, 64, 64};
    int exp_k[4]  = '{0, 64, 0, 64};
    checkOutput({tag, "_starts"}, 64'(logq.size()), 64'd4);
    checkOutput({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput({tag, "_order"}, {32'd0, 16'(logq[i].hw_idx), 16'(logq[i].k_idx)},
                  {32'd0, 16'(exp_hw[i]), 16'(exp_k[i])});
      checkOutput({tag, "_size"}, {24'd0, 8'(logq[i].sub_hw), 8'(logq[i].sub_k), 24'(logq[i].hwcij)},
                  {24'd0, 8'd64, 8'd64, 24'd576});
    end
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl_sub", {27'd0, sched_busy, ld_req, st_req, bp_ex_tile_start, sched_done,
                                   bp_subtile_HW, bp_subtile_K, bp_subtile_CIJ}, 64'd0);
    checkOutput("reset_hwcij_idx", {8'd0, bp_opt_subtile_HWCIJ, tile_hw_idx, tile_k_idx}, 64'd0);
`ifdef BP_TILE_SCHED_PERF_EN
    checkOutput("reset_perf", {perf_busy_cycles, perf_ex_cycles | perf_stall_cycles}, 64'd0);
`endif
    #2 rst = 1'b0;
    cmp_en = 1;

    // 128x128 layer: four full tiles, K inner.
    applyStimulus(128, 128, 9, 2, 3, 2, 0);
    check_square_log("sq");

    // 100x70 layer: edge tiles clipped to the remainder.
    applyStimulus(100, 70, 3, 1, 2, 1, 0);
    checkOutput("edge_starts", 64'(logq.size()), 64'd4);
    checkOutput("edge_t1", {32'd0, 8'(logq[1].sub_hw), 8'(logq[1].sub_k), 16'(logq[1].k_idx)},
                {32'd0, 8'd64, 8'd6, 16'd64});
    checkOutput("edge_t2", {32'd0, 8'(logq[2].sub_hw), 8'(logq[2].sub_k), 16'(logq[2].hw_idx)},
                {32'd0, 8'd36, 8'd64, 16'd64});
    checkOutput("edge_t3", {24'd0, 8'(logq[3].sub_hw), 8'(logq[3].sub_k), 24'(logq[3].hwcij)},
                {24'd0, 8'd36, 8'd6, 24'd108});

    // K = 0: nothing is loaded or executed, done two cycles after start.
    applyStimulus(50, 0, 4, 1, 2, 1, 0);
    checkOutput("zero_ld_cycles", 64'(ld_cnt), 64'd0);
    checkOutput("zero_starts", 64'(logq.size()), 64'd0);
    checkOutput("zero_done_cnt", 64'(done_cnt), 64'd1);

    // Stray ld_done, early tile end and repeated cfg_start during EXEC.
    applyStimulus(128, 128, 9, 2, 4, 1, 1);
    check_square_log("noise");

    // Reset in the middle of EXEC, then a fresh run from tile 0.
    @(negedge clk);
    cfg_HW = 16'd128; cfg_K = 16'd128; cfg_CIJ = 16'd9;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_ld_or_done(ok);
    ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_ctrl_sub", {27'd0, sched_busy, ld_req, st_req, bp_ex_tile_start, sched_done,
                                       bp_subtile_HW, bp_subtile_K, bp_subtile_CIJ}, 64'd0);
    checkOutput("rst_async_hwcij_idx", {8'd0, bp_opt_subtile_HWCIJ, tile_hw_idx, tile_k_idx}, 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    applyStimulus(128, 128, 9, 3, 2, 2, 0);
    check_square_log("after_rst");

`ifdef BP_TILE_SCHED_PERF_EN
    // Single tile: LOAD 5, EXEC 10, STORE 4 cycles plus CALC, NEXT, DONE.
    applyStimulus(10, 10, 2, 5, 10, 4, 0);
    checkOutput("perf_ex", 64'(perf_ex_cycles), 64'd10);
    checkOutput("perf_stall", 64'(perf_stall_cycles), 64'd9);
    checkOutput("perf_busy", 64'(perf_busy_cycles), 64'd22);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=still_running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
